rbm_argmax_scorer: RTL



---
 rtl/rbm_argmax_scorer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/rbm_argmax_scorer.sv
// Consumes the RBM class-score vector once per finish level, scans it for the signed argmax
// and keeps saturating correct/total counts for accuracy measurement.
module rbm_argmax_scorer #(
    parameter int unsigned bitlength   = 12,
    parameter int unsigned output_dim  = 2,
    parameter int unsigned label_width = 8,
    parameter int unsigned count_width = 16
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              finish,
    input  logic [output_dim*bitlength-1:0]   OutputData,
    input  logic [label_width-1:0]            label,
    input  logic                              clear_counts,
    output logic                              busy,
    output logic                              result_valid,
    output logic [label_width-1:0]            predicted,
    output logic                              correct,
    output logic [count_width-1:0]            correct_count,
    output logic [count_width-1:0]            total_count
);

    localparam int unsigned IdxWidth = (output_dim > 1) ? $clog2(output_dim) : 1;
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(output_dim - 1);
    localparam logic [count_width-1:0] CntMax = '1;

    typedef enum logic [1:0] {StIdle, StScan, StReport, StWaitLow} state_e;

    state_e state_q, state_d;

    logic [output_dim*bitlength-1:0] scores_q, scores_d;
    logic [label_width-1:0]          label_q, label_d;
    logic signed [bitlength-1:0]     best_q, best_d;
    logic [IdxWidth-1:0]             best_idx_q, best_idx_d;
    logic [IdxWidth-1:0]             idx_q, idx_d;
    logic                            busy_q, busy_d;
    logic                            valid_q, valid_d;
    logic [label_width-1:0]          predicted_q, predicted_d;
    logic                            correct_q, correct_d;
    logic [count_width-1:0]          correct_cnt_q, correct_cnt_d;
    logic [count_width-1:0]          total_cnt_q, total_cnt_d;

    logic signed [bitlength-1:0]          entry;
    logic [label_width+IdxWidth-1:0]      best_idx_ext;
    logic [label_width+IdxWidth-1:0]      label_ext;
    logic                                 label_match;

    assign entry        = scores_q[int'(idx_q)*bitlength +: bitlength];
    // Widen both sides so out-of-range labels never alias onto a valid index.
    assign best_idx_ext = {{label_width{1'b0}}, best_idx_q};
    assign label_ext    = {{IdxWidth{1'b0}}, label_q};
    assign label_match  = (best_idx_ext == label_ext);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            scores_q      <= '0;
            label_q       <= '0;
            best_q        <= '0;
            best_idx_q    <= '0;
            idx_q         <= '0;
            busy_q        <= 1'b0;
            valid_q       <= 1'b0;
            predicted_q   <= '0;
            correct_q     <= 1'b0;
            correct_cnt_q <= '0;
            total_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            scores_q      <= scores_d;
            label_q       <= label_d;
            best_q        <= best_d;
            best_idx_q    <= best_idx_d;
            idx_q         <= idx_d;
            busy_q        <= busy_d;
            valid_q       <= valid_d;
            predicted_q   <= predicted_d;
            correct_q     <= correct_d;
            correct_cnt_q <= correct_cnt_d;
            total_cnt_q   <= total_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (finish) state_d = (output_dim > 1) ? StScan : StReport;
            StScan:    if (idx_q == LastIdx) state_d = StReport;
            StReport:  state_d = StWaitLow;
            StWaitLow: if (!finish) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        scores_d      = scores_q;
        label_d       = label_q;
        best_d        = best_q;
        best_idx_d    = best_idx_q;
        idx_d         = idx_q;
        busy_d        = (state_d != StIdle);
        valid_d       = 1'b0;
        predicted_d   = predicted_q;
        correct_d     = correct_q;
        correct_cnt_d = correct_cnt_q;
        total_cnt_d   = total_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (finish) begin
                    scores_d   = OutputData;
                    label_d    = label;
                    best_d     = OutputData[bitlength-1:0];
                    best_idx_d = '0;
                    idx_d      = IdxWidth'(1);
                end
            end
            StScan: begin
                // Strict compare keeps the lowest index on ties.
                if (entry > best_q) begin
                    best_d     = entry;
                    best_idx_d = idx_q;
                end
                idx_d = idx_q + 1'b1;
            end
            StReport: begin
                valid_d     = 1'b1;
                predicted_d = best_idx_ext[label_width-1:0];
                correct_d   = label_match;
                if (total_cnt_q != CntMax) total_cnt_d = total_cnt_q + 1'b1;
                if (label_match && correct_cnt_q != CntMax) correct_cnt_d = correct_cnt_q + 1'b1;
            end
            default: ;
        endcase

        if (clear_counts) begin
            correct_cnt_d = '0;
            total_cnt_d   = '0;
        end
    end

    assign busy          = busy_q;
    assign result_valid  = valid_q;
    assign predicted     = predicted_q;
    assign correct       = correct_q;
    assign correct_count = correct_cnt_q;
    assign total_count   = total_cnt_q;

endmodule
